// File: rtl/riscv_mdu_iter.sv
// riscv_mdu_iter: iterative RISC-V M-extension multiply/divide unit.
// Shift-add multiplier and restoring divider, one bit per cycle, sharing a
// single 2*WORD_WIDTH accumulator. Valid/ready on both sides, kill_i flushes.
// Optional feature macro: RISCV_MDU_FAST_MUL_EN selects a single-cycle array
// multiplier for MUL/MULH/MULHSU/MULHU; divides are unaffected.
module riscv_mdu_iter #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            op_i,
  input  logic [WORD_WIDTH-1:0] operand_a_i,
  input  logic [WORD_WIDTH-1:0] operand_b_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [WORD_WIDTH-1:0] result_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic                  kill_i
);

  localparam int CNT_WIDTH = $clog2(WORD_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WORD_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] MOST_NEG = {1'b1, {(WORD_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q;
  logic [2*WORD_WIDTH-1:0]   acc_q;    // product, or {remainder, quotient}
  logic [WORD_WIDTH-1:0]     opnd_q;   // multiplicand or divisor magnitude
  logic [2:0]                op_q;
  logic                      neg_q;    // apply two's-complement in FIXUP

  // ---------------------------------------------------------------------
  // Accept-time decode: signedness, magnitudes and special divide cases
  // ---------------------------------------------------------------------
  logic                  accept;
  logic                  is_div;
  logic                  a_signed, b_signed;
  logic                  sign_a, sign_b;
  logic [WORD_WIDTH-1:0] a_mag, b_mag;
  logic                  div_by_zero, div_ovf, special;
  logic [WORD_WIDTH-1:0] special_res;
  logic                  neg_res;

  // kill_i wins over a simultaneous request, so it blocks the accept here
  assign accept   = valid_i && (state_q == S_IDLE) && !kill_i;
  assign ready_o  = (state_q == S_IDLE);
  assign is_div   = op_i[2];

  assign a_signed = (op_i == 3'b001) || (op_i == 3'b010) ||
                    (op_i == 3'b100) || (op_i == 3'b110);
  assign b_signed = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
  assign sign_a   = a_signed && operand_a_i[WORD_WIDTH-1];
  assign sign_b   = b_signed && operand_b_i[WORD_WIDTH-1];
  // Negating the most negative value yields the same bit pattern, which is
  // exactly its unsigned magnitude, so no special handling is needed here.
  assign a_mag    = sign_a ? -operand_a_i : operand_a_i;
  assign b_mag    = sign_b ? -operand_b_i : operand_b_i;

  assign div_by_zero = is_div && (operand_b_i == '0);
  assign div_ovf     = is_div && !op_i[0] && (operand_a_i == MOST_NEG) &&
                       (operand_b_i == '1);
  assign special     = div_by_zero || div_ovf;

  // Remainder follows the dividend; quotient and product follow sign(a)^sign(b)
  assign neg_res = (is_div && op_i[1]) ? sign_a : (sign_a ^ sign_b);

  // Special-case result selection (divide by zero takes precedence)
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    special_res = '0;
    if (div_by_zero) begin
      special_res = op_i[1] ? operand_a_i : '1;
    end else if (div_ovf) begin
      special_res = op_i[1] ? '0 : operand_a_i;
    end
  end

`ifdef RISCV_MDU_FAST_MUL_EN
  logic [2*WORD_WIDTH-1:0] fast_prod;
  assign fast_prod = {{WORD_WIDTH{1'b0}}, a_mag} * {{WORD_WIDTH{1'b0}}, b_mag};
`endif

  // ---------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------
  logic [WORD_WIDTH:0]     mul_sum;
  logic [2*WORD_WIDTH-1:0] mul_next;
  logic [WORD_WIDTH:0]     div_shift, div_diff;
  logic [2*WORD_WIDTH-1:0] div_next;

  // Shift-add: low half holds the unconsumed multiplier bits, LSB first
  assign mul_sum  = {1'b0, acc_q[2*WORD_WIDTH-1:WORD_WIDTH]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(WORD_WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WORD_WIDTH-1:1]};

  // Restoring divide: shift next dividend bit into the partial remainder;
  // bit WORD_WIDTH of the difference is the borrow (remainder < divisor).
  assign div_shift = acc_q[2*WORD_WIDTH-1:WORD_WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[WORD_WIDTH]
                   ? {div_shift[WORD_WIDTH-1:0], acc_q[WORD_WIDTH-2:0], 1'b0}
                   : {div_diff[WORD_WIDTH-1:0],  acc_q[WORD_WIDTH-2:0], 1'b1};

  // ---------------------------------------------------------------------
  // Sign correction and result selection for FIXUP
  // ---------------------------------------------------------------------
  logic [2*WORD_WIDTH-1:0] prod_fix;
  logic [WORD_WIDTH-1:0]   quo_fix, rem_fix, fixup_res;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[WORD_WIDTH-1:0] : acc_q[WORD_WIDTH-1:0];
  assign rem_fix  = neg_q ? -acc_q[2*WORD_WIDTH-1:WORD_WIDTH]
                          :  acc_q[2*WORD_WIDTH-1:WORD_WIDTH];

  // Pick low/high product word or quotient/remainder according to latched op
  always_comb begin
    fixup_res = '0;
    if (op_q[2]) begin
      fixup_res = op_q[1] ? rem_fix : quo_fix;
    end else if (op_q[1:0] == 2'b00) begin
      fixup_res = prod_fix[WORD_WIDTH-1:0];
    end else begin
      fixup_res = prod_fix[2*WORD_WIDTH-1:WORD_WIDTH];
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic; kill_i returns to IDLE from any state
  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            if (special) begin
              state_d = S_DONE;
            end else if (is_div) begin
              state_d = S_DIV;
            end else begin
`ifdef RISCV_MDU_FAST_MUL_EN
              // Array product is captured at accept; only sign fixup remains
              state_d = S_FIXUP;
`else
              state_d = S_MUL;
`endif
            end
          end
        end
        S_MUL, S_DIV: begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIXUP;
          end
        end
        S_FIXUP: state_d = S_DONE;
        S_DONE: begin
          if (ready_i) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath registers: operand latch, iteration, result and valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every datapath register is reset so a mid-operation reset leaves no stale state.
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= (state_d == S_DONE);
      if (accept) begin
        op_q  <= op_i;
        neg_q <= neg_res;
        cnt_q <= '0;
        if (special) begin
          result_o <= special_res;
        end else if (is_div) begin
          acc_q  <= {{WORD_WIDTH{1'b0}}, a_mag};
          opnd_q <= b_mag;
        end else begin
`ifdef RISCV_MDU_FAST_MUL_EN
          acc_q  <= fast_prod;
          opnd_q <= a_mag;
`else
          acc_q  <= {{WORD_WIDTH{1'b0}}, b_mag};
          opnd_q <= a_mag;
`endif
        end
      end else if (!kill_i) begin
        case (state_q)
          S_MUL: begin
            acc_q <= mul_next;
            cnt_q <= cnt_q + CNT_ONE;
          end
          S_DIV: begin
            acc_q <= div_next;
            cnt_q <= cnt_q + CNT_ONE;
          end
          S_FIXUP: result_o <= fixup_res;
          default: ;
        endcase
      end
    end
  end

endmodule
